// File: rtl/adder_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adder_result_fifo
// Description : Captures {carry, s} from a fixed-latency pipelined adder and
//               buffers the results in a first-word fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_result_fifo #(
    parameter int WIDTH   = 3,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             s,
    input  logic                         carry,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH:0]               out_sum,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [7:0]                   drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [LATENCY-1:0] r_vpipe;
    logic [WIDTH:0]     r_mem [DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic [7:0]         r_drop_count;

    logic w_cap;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    generate
        if (LATENCY == 1) begin : g_pipe_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= in_valid;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= {r_vpipe[LATENCY-2:0], in_valid};
                end
            end
        end
    endgenerate

    assign w_cap  = r_vpipe[LATENCY-1];
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = (r_count != '0) && out_ready;
    // A full FIFO can still accept a result when the head leaves at the same edge.
    assign w_push = w_cap && (!w_full || w_pop);
    assign w_drop = w_cap && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {carry, s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // Gating on count keeps out_sum at zero while reset holds count cleared.
    assign out_valid  = (r_count != '0);
    assign out_sum    = out_valid ? r_mem[r_rptr] : '0;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_adder_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_result_fifo
// Description : Randomized self-checking bench with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_fifo;

    localparam int WIDTH   = 3;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 4;

    logic                       clk       = 1'b0;
    logic                       rst_n     = 1'b0;
    logic                       in_valid  = 1'b0;
    logic [WIDTH-1:0]           s         = '0;
    logic                       carry     = 1'b0;
    logic                       out_ready = 1'b0;
    logic                       out_valid;
    logic [WIDTH:0]             out_sum;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       overflow;
    logic [7:0]                 drop_count;

    adder_result_fifo #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .s          (s),
        .carry      (carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Reference state: history of sampled in_valid, FIFO contents, drop tally.
    bit vh[$];
    int q[$];
    bit m_ovf;
    int m_drops;
    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_valid", int'(out_valid), int'(q.size() != 0));
        chk("count", int'(count), q.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("drop_count", int'(drop_count), m_drops);
        if (q.size() != 0) begin
            chk("out_sum", int'(out_sum), q[0]);
        end
    endtask

    // One clock edge: predict from pre-edge inputs, then compare after the edge.
    task automatic step();
        bit cap;
        bit pop;
        bit push;
        int data;
        cap  = (vh.size() >= LATENCY) ? vh[vh.size() - LATENCY] : 1'b0;
        vh.push_back(in_valid);
        if (vh.size() > 32) begin
            void'(vh.pop_front());
        end
        pop  = (q.size() != 0) && out_ready;
        push = cap && ((q.size() < DEPTH) || pop);
        data = int'({carry, s});
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
        end
        if (push) begin
            q.push_back(data);
        end else if (cap) begin
            m_ovf = 1'b1;
            if (m_drops < 255) begin
                m_drops++;
            end
        end
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        vh.delete();
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_drop_count", int'(drop_count), 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_count", int'(count), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic run(input int n, input int pv, input int pr);
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(99) < pv);
            out_ready = ($urandom_range(99) < pr);
            s         = WIDTH'($urandom);
            carry     = 1'($urandom);
            step();
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single result.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        s     = 3'b101;
        carry = 1'b1;
        step();
        chk("single_sum", int'(out_sum), 13);
        chk("single_count", int'(count), 1);

        // Drain, then stall with five pulses.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 5);
            s        = WIDTH'($urandom);
            carry    = 1'($urandom);
            step();
        end
        chk("stall_count", int'(count), 4);
        chk("stall_overflow", int'(overflow), 1);
        chk("stall_drops", int'(drop_count), 1);

        // Full FIFO, push and pop at the same edge.
        in_valid = 1'b1;
        s        = 3'b011;
        step();
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        carry     = 1'b0;
        s         = 3'b110;
        step();
        out_ready = 1'b0;
        chk("full_pp_count", int'(count), 4);
        chk("full_pp_drops", int'(drop_count), 1);
        run(6, 0, 100);

        // Streaming with s tagged by launch index.
        out_ready = 1'b1;
        for (int i = 0; i < 20 + LATENCY; i++) begin
            in_valid = (i < 20);
            s        = WIDTH'(i - LATENCY);
            carry    = 1'b0;
            step();
        end

        // Reset with a result in flight.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        do_reset();
        run(4, 0, 0);
        chk("midflight_count", int'(count), 0);

        // Alternating write and pop.
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            s         = WIDTH'($urandom);
            step();
            in_valid = 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                s     = WIDTH'($urandom);
                carry = 1'($urandom);
                step();
            end
            out_ready = 1'b1;
            step();
        end
        chk("wrap_count", int'(count), 0);

        // Random mix, then saturate the drop counter.
        run(300, 50, 60);
        run(300, 100, 0);
        chk("drop_saturate", int'(drop_count), 255);
        run(30, 0, 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
